// File: rtl/ifu_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_axi_pkg
//  Description : Shared types and AXI response codes for the IFU fetch bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_axi_pkg;

  // Fetch bridge states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_t;

  // AXI4 read response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ifu_axi_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_axi_fetch
//  Description : Turns IFU fetch requests into single-beat AXI4-Lite reads,
//                returns the word on an rvalid/ready handshake and discards
//                in-flight fetches on pipeline redirect (flush).
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_axi_fetch
  import ifu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  // IFU side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  input  logic              i_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rerr,
  // AXI4-Lite read master
  output logic [ADDR_W-1:0] o_m_araddr,
  output logic              o_m_arvalid,
  input  logic              i_m_arready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  input  logic              i_m_rvalid,
  output logic              o_m_rready
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_drop_pend;
  logic [ADDR_W-1:0] r_araddr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rerr;

  logic              w_fetch;
  logic              w_misaligned;

  assign w_fetch      = i_req & ~i_flush;
  assign w_misaligned = |i_pc[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; an AR already presented is never retracted, so a
  // flush seen in AR is remembered and resolved when the address is accepted
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fetch) begin
          w_state_nxt = w_misaligned ? ST_HOLD : ST_AR;
        end
      end
      ST_AR: begin
        if (i_m_arready) begin
          w_state_nxt = (i_flush | r_drop_pend) ? ST_DROP : ST_R;
        end
      end
      ST_R: begin
        if (i_m_rvalid) begin
          w_state_nxt = i_flush ? ST_IDLE : ST_HOLD;
        end else if (i_flush) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (i_m_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // a handshake wins over a simultaneous flush
        if (i_ready | i_flush) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state only: no combinational path from IFU inputs
  always_comb begin
    o_m_arvalid = (r_state == ST_AR);
    o_m_rready  = (r_state == ST_R) || (r_state == ST_DROP);
    o_rvalid    = (r_state == ST_HOLD);
  end

  // Sticky record of a flush seen while the address was still unaccepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_pend <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_drop_pend <= 1'b0;
    end else if ((r_state == ST_AR) && i_flush) begin
      r_drop_pend <= 1'b1;
    end
  end

  // Address latch on issue; result latch on fault or accepted read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_fetch) begin
        if (w_misaligned) begin
          r_rdata <= '0;
          r_rerr  <= 1'b1;
        end else begin
          r_araddr <= i_pc;
        end
      end
      if ((r_state == ST_R) && i_m_rvalid && !i_flush) begin
        r_rdata <= i_m_rdata;
        r_rerr  <= (i_m_rresp != RESP_OKAY);
      end
    end
  end

  assign o_m_araddr = r_araddr;
  assign o_rdata    = r_rdata;
  assign o_rerr     = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_ifu_axi_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_axi_fetch
//  Description : Self-checking bench for ifu_axi_fetch: directed scenarios
//                followed by randomized IFU/slave traffic against a
//                transaction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rerr;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int n_checks = 0;
  int n_errors = 0;

  ifu_axi_fetch #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req),
    .i_pc        (pc),
    .i_flush     (flush),
    .i_ready     (ready),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_rerr      (rerr),
    .o_m_araddr  (m_araddr),
    .o_m_arvalid (m_arvalid),
    .i_m_arready (m_arready),
    .i_m_rdata   (m_rdata),
    .i_m_rresp   (m_rresp),
    .i_m_rvalid  (m_rvalid),
    .o_m_rready  (m_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents and response code as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    logic [4:0] k;
    k = a[6:2];
    case (k)
      5'd31:   return 2'b10;
      5'd30:   return 2'b11;
      5'd29:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // What the IFU must see for a given fetch address
  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 32'h0 : mem_word(a);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 1'b1 : (mem_resp(a) != 2'b00);
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({tag, "_rready"},  32'(m_rready),  32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),    32'd0);
    chk({tag, "_rerr"},    32'(rerr),      32'd0);
    chk({tag, "_rdata"},   rdata,          32'd0);
    chk({tag, "_araddr"},  m_araddr,       32'd0);
  endtask

  // Called at a negedge while the bridge is in AR: completes the read with a
  // zero-wait beat and checks the word presented to the IFU
  task automatic finish_fetch(input string tag, input logic [31:0] d, input logic [1:0] rs,
                              input logic e_err);
    m_arready = 1'b1;
    nxt();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = d;
    m_rresp   = rs;
    nxt();
    m_rvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"},  rdata,       d);
    chk({tag, "_rerr"},   32'(rerr),   32'(e_err));
    req   = 1'b0;
    ready = 1'b1;
    nxt();
    chk({tag, "_done"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int nrv;
    int narv;
    // random-phase state
    logic        p_ar_hs, p_r_hs, p_arvalid, p_ifu_hs;
    logic [31:0] p_araddr;
    logic        s_pend;
    logic [31:0] s_addr;
    int          s_dly;
    int          wd;

    // ---------------- reset ----------------
    nxt();
    nxt();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    nxt();

    // ---------------- zero-wait fetch and back-to-back issue ----------------
    req = 1'b1; pc = 32'h8000_0000; ready = 1'b1; m_arready = 1'b1;
    nxt();                                                    // cycle 1
    chk("t1_arvalid", 32'(m_arvalid), 32'd1);
    chk("t1_araddr", m_araddr, 32'h8000_0000);
    nxt();                                                    // cycle 2
    chk("t1_rready", 32'(m_rready), 32'd1);
    chk("t1_rvalid_early", 32'(rvalid), 32'd0);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0413; m_rresp = 2'b00;
    nxt();                                                    // cycle 3
    chk("t1_rvalid", 32'(rvalid), 32'd1);
    chk("t1_rdata", rdata, 32'h0000_0413);
    chk("t1_rerr", 32'(rerr), 32'd0);
    m_rvalid = 1'b0;
    nxt();                                                    // cycle 4
    chk("t1_idle", 32'(m_arvalid | rvalid), 32'd0);
    pc = 32'h8000_0004;
    nxt();                                                    // cycle 5
    chk("t1_arvalid2", 32'(m_arvalid), 32'd1);
    chk("t1_araddr2", m_araddr, 32'h8000_0004);
    finish_fetch("t1b", 32'h0010_0093, 2'b00, 1'b0);

    // ---------------- address-channel stall ----------------
    req = 1'b1; pc = 32'h8000_0010; ready = 1'b1; m_arready = 1'b0;
    nrv = 0;
    for (int c = 1; c <= 14; c++) begin
      nxt();
      if (rvalid) nrv++;
      if (c <= 4) begin
        chk("t2_arvalid", 32'(m_arvalid), 32'd1);
        chk("t2_araddr", m_araddr, 32'h8000_0010);
      end
      if (c == 4) m_arready = 1'b1;
      if (c == 5) m_arready = 1'b0;
      if (c == 7) begin
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b00;
      end
      if (c == 8) begin
        chk("t2_rvalid", 32'(rvalid), 32'd1);
        chk("t2_rdata", rdata, 32'hCAFE_0001);
        m_rvalid = 1'b0;
        req = 1'b0;
      end
    end
    chk("t2_pulses", 32'(nrv), 32'd1);

    // ---------------- flush while in AR ----------------
    req = 1'b1; pc = 32'h8000_0020; m_arready = 1'b0;
    nxt();                                                    // cycle 1
    chk("t3_arvalid", 32'(m_arvalid), 32'd1);
    flush = 1'b1; pc = 32'h8000_0100;
    nxt();                                                    // cycle 2
    chk("t3_ar_held", 32'(m_arvalid), 32'd1);
    chk("t3_araddr_held", m_araddr, 32'h8000_0020);
    flush = 1'b0; m_arready = 1'b1;
    nxt();                                                    // cycle 3
    chk("t3_rready", 32'(m_rready), 32'd1);
    chk("t3_no_rvalid", 32'(rvalid), 32'd0);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0; m_rresp = 2'b00;
    nxt();                                                    // cycle 4
    chk("t3_dropped", 32'(rvalid), 32'd0);
    m_rvalid = 1'b0;
    nxt();                                                    // cycle 5
    chk("t3_reissue", 32'(m_arvalid), 32'd1);
    chk("t3_new_addr", m_araddr, 32'h8000_0100);
    finish_fetch("t3b", mem_word(32'h8000_0100), 2'b00, 1'b0);

    // ---------------- flush with the read beat ----------------
    req = 1'b1; pc = 32'h8000_0200; m_arready = 1'b1;
    nxt();                                                    // cycle 1
    chk("t4_arvalid", 32'(m_arvalid), 32'd1);
    nxt();                                                    // cycle 2
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678; flush = 1'b1;
    pc = 32'h8000_0300;
    nxt();                                                    // cycle 3
    chk("t4_idle_rready", 32'(m_rready), 32'd0);
    chk("t4_idle_rvalid", 32'(rvalid), 32'd0);
    flush = 1'b0; m_rvalid = 1'b0;
    nxt();                                                    // cycle 4
    chk("t4_reissue", m_araddr, 32'h8000_0300);
    finish_fetch("t4b", 32'h0000_0013, 2'b00, 1'b0);

    // ---------------- flush in HOLD under back-pressure ----------------
    req = 1'b1; pc = 32'h8000_0400; ready = 1'b0; m_arready = 1'b1;
    nxt();
    nxt();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    nxt();
    chk("t4c_rvalid", 32'(rvalid), 32'd1);
    m_rvalid = 1'b0;
    nxt();
    chk("t4c_hold", 32'(rvalid), 32'd1);
    chk("t4c_hold_data", rdata, 32'h5555_AAAA);
    flush = 1'b1; req = 1'b0;
    nxt();
    chk("t4c_flushed", 32'(rvalid), 32'd0);
    flush = 1'b0; ready = 1'b1;

    // ---------------- error responses ----------------
    req = 1'b1; pc = 32'h8000_0500;
    nxt();
    chk("t5_arvalid", 32'(m_arvalid), 32'd1);
    finish_fetch("t5_slverr", 32'hDEAD_BEEF, 2'b10, 1'b1);

    req = 1'b1; pc = 32'h8000_0002; rerr_seed_clear();
    narv = 0;
    nxt();
    if (m_arvalid) narv++;
    chk("t5_mis_rvalid", 32'(rvalid), 32'd1);
    chk("t5_mis_rerr", 32'(rerr), 32'd1);
    chk("t5_mis_rdata", rdata, 32'd0);
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      if (m_arvalid) narv++;
    end
    chk("t5_mis_no_ar", 32'(narv), 32'd0);

    // ---------------- reset during R ----------------
    req = 1'b1; pc = 32'h8000_0600; m_arready = 1'b1;
    nxt();
    nxt();
    chk("t6_in_r", 32'(m_rready), 32'd1);
    m_arready = 1'b0; req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      check_reset_outputs("t6_after");
      m_rvalid = 1'b0;
    end

    // ---------------- randomized traffic ----------------
    p_ar_hs = 1'b0; p_r_hs = 1'b0; p_arvalid = 1'b0; p_ifu_hs = 1'b0;
    p_araddr = 32'h0; s_pend = 1'b0; s_addr = 32'h0; s_dly = 0; wd = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      nxt();
      // account for what was exchanged at the last clock edge
      if (p_r_hs) s_pend = 1'b0;
      if (p_ar_hs) begin
        s_pend = 1'b1;
        s_addr = p_araddr;
        s_dly  = int'($urandom_range(0, 3));
      end

      if (m_arvalid) chk("r_one_outstanding", 32'(s_pend), 32'd0);
      if (m_arvalid && !p_arvalid) begin
        chk("r_araddr_issue", m_araddr, pc);
        chk("r_araddr_align", 32'(m_araddr[1:0]), 32'd0);
      end
      if (p_arvalid && !p_ar_hs) begin
        chk("r_arvalid_held", 32'(m_arvalid), 32'd1);
        chk("r_araddr_held", m_araddr, p_araddr);
      end
      if (rvalid) begin
        chk("r_rdata", rdata, exp_data(pc));
        chk("r_rerr", 32'(rerr), 32'(exp_err(pc)));
        wd = 0;
      end else if (req) begin
        wd++;
        if (wd > 40) begin
          chk("r_watchdog", 32'(wd), 32'd0);
          wd = 0;
        end
      end

      // IFU: pc moves only after a handshake or together with a flush
      flush = ($urandom_range(0, 15) == 0);
      if (p_ifu_hs || flush) begin
        if ($urandom_range(0, 9) == 0)
          pc = 32'h8000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
        else
          pc = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
      end
      req   = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 3) != 0);

      // slave
      m_arready = $urandom_range(0, 1) == 1;
      if (s_pend && s_dly == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = mem_word(s_addr);
        m_rresp  = mem_resp(s_addr);
      end else begin
        if (s_pend) s_dly--;
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        m_rresp  = 2'($urandom_range(0, 3));
      end

      p_ar_hs   = m_arvalid & m_arready;
      p_r_hs    = m_rvalid & m_rready;
      p_arvalid = m_arvalid;
      p_araddr  = m_araddr;
      p_ifu_hs  = rvalid & ready;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Misaligned fetch needs no slave activity; keep the slave quiet
  task automatic rerr_seed_clear();
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
  endtask

endmodule
`default_nettype wire

// File: doc/ifu_axi_fetch.md
# ifu_axi_fetch

Instruction-fetch bus bridge sitting directly upstream of the IFU. It turns the IFU's fetch request and current `pc` into single-beat AXI4-Lite read transactions toward instruction memory. It returns the fetched word on the IFU's `rvalid`/`rdata` handshake, and discards in-flight fetches when the pipeline redirects.

## Interface
- `ADDR_W`, 32, width of `pc` and `araddr`.
- `DATA_W`, 32, instruction/data width; only 32 is supported.

Clock and reset (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.

IFU side:
- `req` in 1: IFU wants an instruction.
- `pc` in ADDR_W: fetch address; stable until IFU handshake.
- `flush` in 1: redirect (driven from `dnpc_flag`); abandon any outstanding fetch.
- `ready` in 1: IFU accepts `rdata` this cycle.
- `rvalid` out 1: fetched word valid.
- `rdata` out DATA_W: fetched instruction.
- `rerr` out 1: fault on this fetch; qualified by `rvalid`.

AXI4-Lite read master:
- `m_araddr` out ADDR_W
- `m_arvalid` out 1
- `m_arready` in 1
- `m_rdata` in DATA_W
- `m_rresp` in 2
- `m_rvalid` in 1
- `m_rready` out 1

## Operation
- States: IDLE, AR, R, HOLD, DROP.
- IDLE:
  - `req` & !`flush` & `pc[1:0]`==0: latch `m_araddr`<=`pc`, go to AR.
  - `req` & !`flush` & `pc[1:0]`!=0: no bus access; `rdata`<=0, `rerr`<=1, go to HOLD.
- AR:
  - `m_arvalid`=1 and `m_araddr` held stable until `m_arready`. AXI forbids retracting `m_arvalid`.
  - On `m_arready`: go to R, or to DROP if `flush` is seen this cycle or was seen earlier in AR. The sticky `drop_pend` flag records an earlier flush.
- R (`m_rready`=1):
  - `m_rvalid` & !`flush`: `rdata`<=`m_rdata`, `rerr`<=(`m_rresp`!=2'b00), go to HOLD.
  - `m_rvalid` & `flush`: discard the data, go to IDLE.
  - `flush` without `m_rvalid`: go to DROP.
- DROP (`m_rready`=1): on `m_rvalid`, discard the data and go to IDLE. `flush` has no further effect here.
- HOLD:
  - `rvalid`=1; `rdata`/`rerr` stable.
  - `ready`: handshake completes, go to IDLE. This holds even if `flush` is asserted the same cycle.
  - `flush` & !`ready`: drop the word and go to IDLE.
- Only one outstanding AR at a time. `drop_pend` clears on entering IDLE.
- `rdata` is don't-care while `rvalid`=0, but must not change during HOLD.

## Timing
- Reset values: state=IDLE, `m_arvalid`=0, `m_rready`=0, `rvalid`=0, `rerr`=0, `rdata`=0, `m_araddr`=0, `drop_pend`=0.
- Reset asserted mid-transaction returns to IDLE immediately. The slave is assumed reset by the same `rst_n`.
- All outputs are registered or decoded from state only; there is no combinational path from the IFU inputs to AXI outputs.
- Best-case latency, with `req` sampled in IDLE at cycle 0:
  - `m_arvalid` high in cycle 1.
  - With `m_arready`=1 in cycle 1 and `m_rvalid`=1 in cycle 2, `rvalid` is high in cycle 3.
  - After the handshake at cycle 3, IDLE in cycle 4 samples the updated `pc`.
  - Sustained throughput is therefore one instruction per 4 cycles with a zero-wait slave.
- Misaligned `pc`: `rvalid` with `rerr` appears 1 cycle after sampling in IDLE.
- Back-pressure: HOLD persists indefinitely while `ready`=0.

## Structure
- Shared package `ifu_axi_pkg` holds:
  - the state enum (IDLE, AR, R, HOLD, DROP);
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Single module with no sub-module. A later I-cache will replace the slave side, not this FSM.

## Test plan
- Zero-wait slave, `req`=1, `pc`=0x80000000, mem=0x00000413, `ready`=1: `m_araddr`=0x80000000 in cycle 1; `rvalid`/`rdata`=0x00000413 in cycle 3; the next fetch of 0x80000004 issues in cycle 5.
- Slave holding `m_arready` low for 3 cycles, then `m_rvalid` 2 cycles later: `m_arvalid` and `m_araddr` are stable for the whole stall, and exactly one `rvalid` pulse follows.
- `flush` pulsed in AR, with `pc` changed to 0x80000100: the first R beat is consumed with `rvalid`=0. The next issued `m_araddr` is 0x80000100.
- `flush` in R on the same cycle as `m_rvalid`: the data is dropped and the state goes straight to IDLE. `flush` in HOLD with `ready`=0: `rvalid` falls the next cycle.
- `m_rresp`=2'b10, `rdata`=0xDEADBEEF: `rvalid`=1 with `rerr`=1. Separately, `pc`=0x80000002: `rerr`=1, `rdata`=0, and no `m_arvalid` is ever raised.
- `rst_n` dropped while in R, with the slave still asserting `m_rvalid` after release: the response is not forwarded to the IFU, and all outputs are at their reset values.
